// File: rtl/delay_timer_arbiter.sv
// Shared delay timer: one prescaler and one down-counter time-shared between
// NUM_REQ requesters through a round-robin arbiter. All outputs are registered.
module delay_timer_arbiter #(
  parameter int TICK_DIVISOR = 50,
  parameter int TICK_SIZE    = 6,
  parameter int NUM_REQ      = 4,
  parameter int DELAY_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             request,
  input  logic [NUM_REQ*DELAY_WIDTH-1:0] delay_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic                           tick
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [TICK_SIZE-1:0] TICK_LAST  = TICK_SIZE'(TICK_DIVISOR - 1);
  localparam logic                 TICK_EVERY = (TICK_DIVISOR == 1);

  logic [1:0]             state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last_grant;
  logic [TICK_SIZE-1:0]   prescaler;
  logic [DELAY_WIDTH-1:0] remaining;

  logic                   found;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [DELAY_WIDTH-1:0] delay_sel;
  int                     cand;
  logic [IDX_W-1:0]       cand_idx;

  // Round-robin search starting just above the previous owner
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_grant) + off) % NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found && request[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    delay_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) delay_sel = delay_in[i*DELAY_WIDTH +: DELAY_WIDTH];
    end
  end

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      prescaler  <= '0;
      remaining  <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      tick       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          tick <= 1'b0;
          if (found) begin
            owner     <= win_idx;
            grant     <= win_onehot;
            remaining <= delay_sel;
            prescaler <= '0;
            busy      <= 1'b1;
            if (delay_sel == '0) begin
              state <= DONE;
              done  <= win_onehot;
            end else begin
              state <= COUNT;
              tick  <= TICK_EVERY;
            end
          end
        end

        COUNT: begin
          // Abort wins over a simultaneous expiry: no done pulse once the owner lets go
          if (!request[owner]) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            tick       <= 1'b0;
            prescaler  <= '0;
            last_grant <= owner;
          end else if (prescaler == TICK_LAST) begin
            prescaler <= '0;
            remaining <= remaining - 1'b1;
            if (remaining == DELAY_WIDTH'(1)) begin
              state <= DONE;
              done  <= grant;
              tick  <= 1'b0;
            end else begin
              tick  <= TICK_EVERY;
            end
          end else begin
            // tick is registered, so it is raised one cycle ahead of the terminal count
            prescaler <= prescaler + 1'b1;
            tick      <= ((prescaler + 1'b1) == TICK_LAST);
          end
        end

        DONE: begin
          state      <= IDLE;
          done       <= '0;
          grant      <= '0;
          busy       <= 1'b0;
          tick       <= 1'b0;
          last_grant <= owner;
        end

        default: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
          busy  <= 1'b0;
          tick  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/delay_timer_arbiter.md
# delay_timer_arbiter

Shared delay timer for the sensor-side FPGA logic. One prescaler (a clock-enable divider) and one down-counter are time-shared between up to NUM_REQ requesters, for example the sensor bus driver and the UART framing logic. Each requester asks for a delay of N microsecond-scale ticks. A round-robin arbiter grants the timer to one requester at a time and pulses that requester's done line when its delay expires. Everything runs in the single `clock` domain; the block generates no derived clocks.

## Interface
- TICK_DIVISOR, 50: clock cycles per tick; 1 µs at 50 MHz; legal range 1..2^TICK_SIZE.
- TICK_SIZE, 6: prescaler width; must hold TICK_DIVISOR-1.
- NUM_REQ, 4: number of requesters, 2..8.
- DELAY_WIDTH, 16: width of each delay request, in ticks.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- request  in  NUM_REQ  level request per requester; hold until done or abort.
- delay_in  in  NUM_REQ*DELAY_WIDTH  packed delays; requester i uses bits [i*DELAY_WIDTH +: DELAY_WIDTH]; sampled only on grant.
- grant  out  NUM_REQ  one-hot registered owner of the timer; all zero when idle.
- done  out  NUM_REQ  one-cycle registered pulse to the owner at expiry.
- busy  out  1  high in COUNT or DONE.
- tick  out  1  one-cycle prescaler strobe, for debug; low outside COUNT.

## Operation
- States: IDLE, COUNT, DONE. All outputs are registered.
- Reset (synchronous, overrides everything):
  - state=IDLE; grant, done, busy, tick = 0.
  - prescaler=0; remaining=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority first.
- IDLE, any request bit high:
  - Winner is the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Set grant=onehot(winner), latch remaining=delay_in[winner], clear prescaler, set busy.
  - If the latched delay is 0: go to DONE and assert done[winner] on the same edge.
  - Otherwise go to COUNT.
- COUNT:
  - Each cycle, prescaler increments.
  - When prescaler==TICK_DIVISOR-1: prescaler returns to 0, tick pulses, remaining decrements.
  - If remaining was 1 at that tick: go to DONE and assert done[winner] on the same edge.
- DONE:
  - Lasts exactly one cycle.
  - Next edge: done=0, grant=0, busy=0, last_grant=winner, state=IDLE.
- Abort:
  - If request[winner] is low on any COUNT edge, go to IDLE next edge.
  - grant and busy clear, last_grant=winner, no done pulse.
  - Requests from non-owners during COUNT are ignored; no preemption.
- Back-to-back:
  - A requester that still holds request in IDLE is re-arbitrated as a new request. Round-robin gives other pending requesters precedence.
  - IDLE always lasts at least one cycle between grants.
- delay_in changes after grant have no effect.
- Reset asserted mid-COUNT or mid-DONE: outputs clear on that edge; any pending done is discarded.

## Timing
- Request high before edge k with the block in IDLE: grant is valid after edge k. This is the delay-latch edge.
- Delay D≥1: done is high for the single cycle after edge k+D*TICK_DIVISOR. Grant clears at edge k+D*TICK_DIVISOR+1.
- D=0: grant and done rise together at edge k; both clear at edge k+1.
- First tick strobe is high in the cycle before edge k+TICK_DIVISOR. Tick period is exactly TICK_DIVISOR cycles.
- TICK_DIVISOR=1: tick is high every COUNT cycle, so the delay is D cycles.
- Minimum grant-to-grant spacing: D*TICK_DIVISOR+2 cycles.
- remaining never underflows and never wraps. Maximum delay is (2^DELAY_WIDTH-1)*TICK_DIVISOR cycles.

## Test plan
All scenarios use TICK_DIVISOR=4, NUM_REQ=4, DELAY_WIDTH=16.
- Reset then idle: grant=0, done=0, busy=0, tick=0 for 10 cycles.
- Single request: request[1] with D=3 before edge k -> grant=4'b0010 at k; tick at cycles k+3, k+7, k+11; done[1] for one cycle after k+12; grant=0 after k+13.
- Simultaneous request[0] and request[2] after reset, each D=2 -> 0 served first (done after k+8), then 2 granted at k+10, done after k+18.
- Fairness: all four requests held high, D=1 -> grant order 0,1,2,3,0, each grant 6 cycles apart.
- D=0 on request[3] -> grant[3] and done[3] rise on the same edge and fall one edge later.
- Abort: request[1] dropped at k+5 of a D=10 delay -> grant=0 after k+6, no done pulse; pending request[2] granted next.
- Reset mid-COUNT at k+6: all outputs 0 after that edge. A fresh request[1] then re-grants starting with priority at requester 0.
